// File: rtl/seq_nibble_adder.sv
// seq_nibble_adder -- multi-cycle WIDTH-bit adder/subtractor built around one
// 4-bit carry-lookahead slice (Adder4). Each cycle in RUN the slice adds one
// nibble. The carry is kept in a register between nibbles. The sum is
// assembled in a shift register and published with its flags once the last
// nibble is done.
//
// Build option: define SEQ_NIBBLE_ADDER_SUB_EN to honour iSub (A-B as A+~B+1).
// When it is left undefined, iSub is ignored and every operation is A+B.
//
// Ports (Adder4):
//   iA, iB   [3:0] nibble operands
//   iC             carry in
//   oS       [3:0] nibble sum
//   oC             carry out of bit 3
//
// Ports (seq_nibble_adder):
//   iClk           rising-edge clock
//   iRst           asynchronous active-high reset
//   iValid/oReady  operand handshake (accepted on an edge with both high)
//   iA, iB   [W]   operands, sampled at acceptance
//   iSub           1 = A-B, 0 = A+B, sampled at acceptance
//   oValid/iReady  result handshake (consumed on an edge with both high)
//   oS       [W]   sum/difference, registered
//   oC             carry out of bit W-1 (no-borrow for subtraction)
//   oOvf           two's-complement signed overflow
//   oZ             oS == 0
//   oState   [2]   current FSM state (debug observation)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid (and its data) until that edge. Ready
// and valid are decoded from the state register only, so no combinational
// path runs from any input to any output.

module Adder4 (
   input  logic [3:0] iA,
   input  logic [3:0] iB,
   input  logic       iC,
   output logic [3:0] oS,
   output logic       oC
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = iA & iB;
   assign p = iA ^ iB;

   // Every carry is expanded from generate/propagate terms so that no carry
   // has to ripple through the previous one.
   assign c[0] = iC;
   assign c[1] = g[0] | (p[0] & iC);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & iC);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & iC);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & iC);

   assign oS = p ^ c[3:0];
   assign oC = c[4];
endmodule

module seq_nibble_adder #(
   parameter int WIDTH = 32
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iValid,
   output logic             oReady,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   input  logic             iSub,
   output logic             oValid,
   input  logic             iReady,
   output logic [WIDTH-1:0] oS,
   output logic             oC,
   output logic             oOvf,
   output logic             oZ,
   output logic [1:0]       oState
);
   localparam int NIB = WIDTH / 4;
   localparam int NW  = $clog2(NIB);
   localparam logic [NW-1:0] LAST_NIB = NW'(NIB - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] rA;
   logic [WIDTH-1:0] rB;
   logic [WIDTH-1:0] rS;
   logic             rC;
   logic [NW-1:0]    rN;
   logic             rAm;    // MSB of A, captured at acceptance
   logic             rBm;    // MSB of the effective (possibly inverted) B

   logic [WIDTH-1:0] b_eff;
   logic             c_init;
   logic [3:0]       slice_s;
   logic             slice_c;
   logic [WIDTH-1:0] res_next;
   logic             last_nib;
   logic [3:0]       unused_rs_low;

`ifdef SEQ_NIBBLE_ADDER_SUB_EN
   // Subtraction is A + ~B + 1. The +1 enters as the carry into nibble 0.
   assign b_eff  = iSub ? ~iB : iB;
   assign c_init = iSub;
`else
   logic unused_sub;
   assign unused_sub = iSub;
   assign b_eff      = iB;
   assign c_init     = 1'b0;
`endif

   Adder4 u_slice (
      .iA (rA[3:0]),
      .iB (rB[3:0]),
      .iC (rC),
      .oS (slice_s),
      .oC (slice_c)
   );

   // The new nibble enters at the top. After NIB shifts, nibble 0 is in bits [3:0].
   assign res_next      = {slice_s, rS[WIDTH-1:4]};
   assign last_nib      = (rN == LAST_NIB);
   assign unused_rs_low = rS[3:0];

   assign oReady = (state == IDLE);
   assign oValid = (state == DONE);
   assign oState = state;

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state <= IDLE;
         rA    <= '0;
         rB    <= '0;
         rS    <= '0;
         rC    <= 1'b0;
         rN    <= '0;
         rAm   <= 1'b0;
         rBm   <= 1'b0;
         oS    <= '0;
         oC    <= 1'b0;
         oOvf  <= 1'b0;
         oZ    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (iValid) begin
                  rA    <= iA;
                  rB    <= b_eff;
                  rC    <= c_init;
                  rN    <= '0;
                  rAm   <= iA[WIDTH-1];
                  rBm   <= b_eff[WIDTH-1];
                  state <= RUN;
               end
            end
            RUN: begin
               rA <= rA >> 4;
               rB <= rB >> 4;
               rS <= res_next;
               rC <= slice_c;
               rN <= rN + 1'b1;
               if (last_nib) begin
                  // The last slice produces the MSB nibble and the final carry.
                  oS    <= res_next;
                  oC    <= slice_c;
                  oOvf  <= (rAm == rBm) & (slice_s[3] != rAm);
                  oZ    <= (res_next == '0);
                  state <= DONE;
               end
            end
            DONE: begin
               if (iReady) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seq_nibble_adder.sv
// Testbench for seq_nibble_adder (WIDTH=32). It uses directed operand vectors
// with hand-computed results. An arithmetic reference model fills expected
// queues at each acceptance. A negedge monitor compares every cycle that
// oValid is high, and a summary line is printed at the end.

module tb_seq_nibble_adder;
   localparam int WIDTH = 32;
   localparam int NIB   = WIDTH / 4;

`ifdef SEQ_NIBBLE_ADDER_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic             iValid;
   logic             oReady;
   logic [WIDTH-1:0] iA;
   logic [WIDTH-1:0] iB;
   logic             iSub;
   logic             oValid;
   logic             iReady;
   logic [WIDTH-1:0] oS;
   logic             oC;
   logic             oOvf;
   logic             oZ;
   logic [1:0]       state_dbg;

   always #5 clk = ~clk;

   seq_nibble_adder #(.WIDTH(WIDTH)) dut (
      .iClk   (clk),
      .iRst   (rst),
      .iValid (iValid),
      .oReady (oReady),
      .iA     (iA),
      .iB     (iB),
      .iSub   (iSub),
      .oValid (oValid),
      .iReady (iReady),
      .oS     (oS),
      .oC     (oC),
      .oOvf   (oOvf),
      .oZ     (oZ),
      .oState (state_dbg)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [2:0]       exp_f_q[$];   // {c, ovf, z}

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: whole-word modular arithmetic, carry = bit WIDTH of the sum.
   task automatic model_push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic sub);
      logic [WIDTH:0]   full;
      logic [WIDTH-1:0] be;
      logic             cin;
      logic             ovf;
      be  = b;
      cin = 1'b0;
      if (sub && SUB_EN) begin
         be  = ~b;
         cin = 1'b1;
      end
      full = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, cin};
      ovf  = (a[WIDTH-1] == be[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
      exp_q.push_back(full[WIDTH-1:0]);
      exp_f_q.push_back({full[WIDTH], ovf, (full[WIDTH-1:0] == '0)});
   endtask

   always @(negedge clk) begin
      if (!rst && oValid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%h required=none", oS);
         end else begin
            check("mon_s", oS, exp_q[0]);
            check("mon_flags", {29'd0, oC, oOvf, oZ}, {29'd0, exp_f_q[0]});
            if (iReady) begin
               void'(exp_q.pop_front());
               void'(exp_f_q.pop_front());
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub, input int hold, input bit toggle,
                         input bit lit_en, input logic [WIDTH-1:0] lit_s,
                         input logic [2:0] lit_f);
      int n;
      logic [WIDTH-1:0] s_hold;
      logic [2:0]       f_hold;
      n = 0;
      while (!oReady && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("ready_before_op", {31'd0, oReady}, 1);
      iA = a; iB = b; iSub = sub; iValid = 1'b1;
      @(posedge clk); #1;
      model_push(a, b, sub);
      // Scrambled operands after acceptance must not disturb the result.
      iValid = 1'b0; iA = ~a; iB = a ^ b; iSub = ~sub;
      n = 0;
      while (!oValid && n < 3 * NIB) begin
         if (toggle) begin
            iValid = n[0];
            iA     = ~iA;
         end
         @(posedge clk); #1;
         n++;
      end
      iValid = 1'b0;
      check("latency", n, NIB);
      check("done_ready_low", {31'd0, oReady}, 0);
      if (lit_en) begin
         check("lit_s", oS, lit_s);
         check("lit_flags", {29'd0, oC, oOvf, oZ}, {29'd0, lit_f});
      end
      s_hold = oS;
      f_hold = {oC, oOvf, oZ};
      repeat (hold) begin
         @(posedge clk); #1;
         check("bp_ready_low", {31'd0, oReady}, 0);
         check("bp_valid_high", {31'd0, oValid}, 1);
         check("bp_hold_s", oS, s_hold);
         check("bp_hold_flags", {29'd0, oC, oOvf, oZ}, {29'd0, f_hold});
      end
      iReady = 1'b1;
      @(posedge clk); #1;
      iReady = 1'b0;
      check("release_ready", {31'd0, oReady}, 1);
      check("release_valid", {31'd0, oValid}, 0);
   endtask

   task automatic reset_mid_op();
      iA = 32'h1111_1111; iB = 32'h2222_2222; iSub = 1'b0; iValid = 1'b1;
      @(posedge clk); #1;
      iValid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_s", oS, 0);
      check("rst_mid_flags", {29'd0, oC, oOvf, oZ}, 0);
      check("rst_mid_ready", {31'd0, oReady}, 1);
      check("rst_mid_valid", {31'd0, oValid}, 0);
      exp_q.delete();
      exp_f_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Subtraction literals depend on whether iSub is honoured.
`ifdef SEQ_NIBBLE_ADDER_SUB_EN
   localparam logic [WIDTH-1:0] SUB57_S = 32'hFFFF_FFFE;
   localparam logic [2:0]       SUB57_F = 3'b000;
   localparam logic [WIDTH-1:0] SUB77_S = 32'h0000_0000;
   localparam logic [2:0]       SUB77_F = 3'b101;
`else
   localparam logic [WIDTH-1:0] SUB57_S = 32'h0000_000C;
   localparam logic [2:0]       SUB57_F = 3'b000;
   localparam logic [WIDTH-1:0] SUB77_S = 32'h0000_000E;
   localparam logic [2:0]       SUB77_F = 3'b000;
`endif

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1; iValid = 1'b0; iReady = 1'b0; iA = '0; iB = '0; iSub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_s", oS, 0);
      check("reset_flags", {29'd0, oC, oOvf, oZ}, 0);
      check("reset_ready", {31'd0, oReady}, 1);
      check("reset_valid", {31'd0, oValid}, 0);
      rst = 1'b0;

      run_op(32'h0000_1234, 32'h0000_4321, 1'b0, 0, 1'b0, 1'b1, 32'h0000_5555, 3'b000);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, 1'b1, 32'h0000_0000, 3'b101);
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 5, 1'b1, 1'b1, 32'h8000_0000, 3'b010);
      reset_mid_op();
      run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 0, 1'b0, 1'b1, 32'h0000_0002, 3'b000);
      run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0, 1'b0, 1'b1, SUB57_S, SUB57_F);
      run_op(32'h0000_0007, 32'h0000_0007, 1'b1, 2, 1'b0, 1'b1, SUB77_S, SUB77_F);
      run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1'b0, 1'b1, 32'h0000_0000, 3'b111);
      run_op(32'h89AB_CDEF, 32'h0123_4567, 1'b0, 1, 1'b1, 1'b1, 32'h8ACF_1356, 3'b000);
      run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 0, 1'b0, 1'b0, '0, 3'b000);
      run_op(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 0, 1'b0, 1'b1, 32'h0000_0000, 3'b101);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_results actual=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
